branch_predictor: RTL and testbench

Parametrised branch prediction and target unit, the successor to the combinational branch target adder. Holds a direct-mapped table of tagged entries, each with a 2-bit saturating counter and a branch target. The table serves same-cycle predictions to IF and is trained by branches resolved in EX. Also produces a registered mispredict/redirect to the PC mux, and supports a multi-cycle table clear.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 142 ++++++++++++++
 tb/tb_branch_predictor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_pkg : shared FSM state and counter encodings for the branch predictor
// Rev 1.0
// ----------------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bp_state_e;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_sat_counter : combinational 2-bit saturating increment/decrement
// Rev 1.0
// ----------------------------------------------------------------------------
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_inc,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_predictor : direct-mapped tagged 2-bit predictor with target store,
// registered mispredict/redirect and a one-entry-per-cycle clear sweep
// Rev 1.0
// ----------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int IMM_SHIFT = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] lookup_PC,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_PC,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_PC,
  input  logic [XLEN-1:0] resolve_imm,
  input  logic            resolve_taken,
  input  logic            resolve_pred_taken,
  input  logic [XLEN-1:0] resolve_pred_PC,
  input  logic            clear,
  output logic            busy,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_PC
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W;

  bp_state_e         r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [XLEN-1:0]   r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic              r_mispredict;
  logic [XLEN-1:0]   r_redirect;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic              w_pred_taken;
  logic [IDX_W-1:0]  w_rs_idx;
  logic [TAG_W-1:0]  w_rs_tag;
  logic              w_rs_hit;
  logic [XLEN-1:0]   w_imm_off;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_correct;
  logic [1:0]        w_ctr_next;
  logic              w_mispredict;

  assign w_lk_idx     = lookup_PC[IDX_W-1:0];
  assign w_lk_tag     = lookup_PC[XLEN-1:IDX_W];
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken = (r_state == IDLE) && w_lk_hit && r_ctr[w_lk_idx][1];

  assign predict_taken = w_pred_taken;
  assign predict_PC    = w_pred_taken ? r_target[w_lk_idx] : lookup_PC + XLEN'(1);
  assign busy          = (r_state == CLEAR);

  assign w_rs_idx  = resolve_PC[IDX_W-1:0];
  assign w_rs_tag  = resolve_PC[XLEN-1:IDX_W];
  assign w_rs_hit  = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);
  // Byte immediate becomes a word offset; sign must survive the shift.
  assign w_imm_off = XLEN'($signed(resolve_imm) >>> IMM_SHIFT);
  assign w_target  = resolve_PC + w_imm_off;
  assign w_correct = resolve_taken ? w_target : resolve_PC + XLEN'(1);

  assign w_mispredict = resolve_valid &&
                        ((resolve_pred_taken != resolve_taken) ||
                         (resolve_pred_PC != w_correct));

  bp_sat_counter u_sat (
    .i_ctr (r_ctr[w_rs_idx]),
    .i_inc (resolve_taken),
    .o_ctr (w_ctr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (resolve_valid) begin
            if (w_rs_hit) begin
              r_ctr[w_rs_idx] <= w_ctr_next;
              if (resolve_taken) r_target[w_rs_idx] <= w_target;
            end else if (resolve_taken) begin
              r_valid[w_rs_idx]  <= 1'b1;
              r_tag[w_rs_idx]    <= w_rs_tag;
              r_target[w_rs_idx] <= w_target;
              r_ctr[w_rs_idx]    <= CTR_ALLOC;
            end
          end
          if (clear) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
        CLEAR: begin
          r_valid[r_ptr] <= 1'b0;
          r_ctr[r_ptr]   <= CTR_RESET;
          if (clear) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + IDX_W'(1);
            if (r_ptr == IDX_W'(ENTRIES - 1)) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Redirect is scored in every state so the pipe still recovers mid-sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
    end else begin
      r_mispredict <= w_mispredict;
      if (resolve_valid) r_redirect <= w_correct;
    end
  end

  assign mispredict  = r_mispredict;
  assign redirect_PC = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_predictor : directed self-checking bench for branch_predictor
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        reset_n;
  logic [31:0] lookup_PC;
  logic        predict_taken;
  logic [31:0] predict_PC;
  logic        resolve_valid;
  logic [31:0] resolve_PC;
  logic [31:0] resolve_imm;
  logic        resolve_taken;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_PC;
  logic        clear;
  logic        busy;
  logic        mispredict;
  logic [31:0] redirect_PC;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .IMM_SHIFT(2)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .lookup_PC          (lookup_PC),
    .predict_taken      (predict_taken),
    .predict_PC         (predict_PC),
    .resolve_valid      (resolve_valid),
    .resolve_PC         (resolve_PC),
    .resolve_imm        (resolve_imm),
    .resolve_taken      (resolve_taken),
    .resolve_pred_taken (resolve_pred_taken),
    .resolve_pred_PC    (resolve_pred_PC),
    .clear              (clear),
    .busy               (busy),
    .mispredict         (mispredict),
    .redirect_PC        (redirect_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] imm, input logic tk,
                         input logic ptk, input logic [31:0] ppc);
    resolve_PC         = pc;
    resolve_imm        = imm;
    resolve_taken      = tk;
    resolve_pred_taken = ptk;
    resolve_pred_PC    = ppc;
    resolve_valid      = 1'b1;
    tick();
    resolve_valid      = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_pc);
    lookup_PC = pc;
    #1;
    check({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
    check({tag, "_pc"}, predict_PC, exp_pc);
  endtask

  task automatic expect_mp(input string tag, input logic mp, input logic [31:0] rd);
    check({tag, "_mp"}, {31'd0, mispredict}, {31'd0, mp});
    if (mp) check({tag, "_redir"}, redirect_PC, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; lookup_PC = 32'h20; resolve_valid = 1'b0; resolve_PC = '0;
    resolve_imm = '0; resolve_taken = 1'b0; resolve_pred_taken = 1'b0;
    resolve_pred_PC = '0; clear = 1'b0;

    // Reset state
    #12;
    look("rst", 32'h20, 1'b0, 32'h21);
    check("rst_mp", {31'd0, mispredict}, 32'd0);
    check("rst_redir", redirect_PC, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #5 reset_n = 1'b1;
    tick();

    // Allocation on taken miss
    resolve(32'h20, 32'h40, 1'b1, 1'b0, 32'h21);
    expect_mp("alloc", 1'b1, 32'h30);
    look("alloc_lk", 32'h20, 1'b1, 32'h30);
    tick();
    check("mp_hold", {31'd0, mispredict}, 32'd0);

    // Saturate up to 11, then one not-taken leaves it at 10
    resolve(32'h20, 32'h40, 1'b1, 1'b1, 32'h30);
    expect_mp("inc1", 1'b0, 32'h0);
    resolve(32'h20, 32'h40, 1'b1, 1'b1, 32'h30);
    resolve(32'h20, 32'h40, 1'b0, 1'b1, 32'h30);
    expect_mp("dec_st", 1'b1, 32'h21);
    look("sat_hi", 32'h20, 1'b1, 32'h30);

    // Down 10 -> 01 -> 00 -> 00
    resolve(32'h20, 32'h40, 1'b0, 1'b1, 32'h30);
    expect_mp("nt1", 1'b1, 32'h21);
    look("nt1_lk", 32'h20, 1'b0, 32'h21);
    resolve(32'h20, 32'h40, 1'b0, 1'b0, 32'h21);
    expect_mp("nt2", 1'b0, 32'h0);
    resolve(32'h20, 32'h40, 1'b0, 1'b0, 32'h21);
    look("sat_lo", 32'h20, 1'b0, 32'h21);
    resolve(32'h20, 32'h40, 1'b1, 1'b0, 32'h21);
    expect_mp("tk_from0", 1'b1, 32'h30);
    look("ctr01", 32'h20, 1'b0, 32'h21);
    resolve(32'h20, 32'h40, 1'b1, 1'b0, 32'h21);
    look("ctr10", 32'h20, 1'b1, 32'h30);

    // Alias at index 0 with a different tag
    look("alias_miss", 32'h30, 1'b0, 32'h31);
    resolve(32'h30, 32'h20, 1'b1, 1'b0, 32'h31);
    expect_mp("replace", 1'b1, 32'h38);
    look("replace_lk", 32'h30, 1'b1, 32'h38);
    look("evicted", 32'h20, 1'b0, 32'h21);

    // Negative immediate
    resolve(32'h40, 32'hFFFF_FFF8, 1'b1, 1'b0, 32'h41);
    expect_mp("negimm", 1'b1, 32'h3E);
    look("negimm_lk", 32'h40, 1'b1, 32'h3E);

    // Clear sweep
    resolve(32'h45, 32'h8, 1'b1, 1'b0, 32'h46);
    look("pre_clr", 32'h45, 1'b1, 32'h47);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) look("clr_force", 32'h45, 1'b0, 32'h46);
      if (n == 5) begin
        resolve_PC = 32'h50; resolve_imm = 32'h10; resolve_taken = 1'b1;
        resolve_pred_taken = 1'b0; resolve_pred_PC = 32'h51; resolve_valid = 1'b1;
      end
      tick();
      resolve_valid = 1'b0;
      if (n == 5) expect_mp("clr_mp", 1'b1, 32'h54);
    end
    check("clr_len", n, 32'd16);
    look("post_clr_a", 32'h40, 1'b0, 32'h41);
    look("post_clr_b", 32'h45, 1'b0, 32'h46);
    look("dropped", 32'h50, 1'b0, 32'h51);

    // Reset in the middle of a sweep
    resolve(32'h4C, 32'h8, 1'b1, 1'b0, 32'h4D);
    resolve(32'h45, 32'h8, 1'b1, 1'b0, 32'h46);
    look("pre_rst", 32'h4C, 1'b1, 32'h4E);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    look("abort_a", 32'h45, 1'b0, 32'h46);
    look("abort_b", 32'h4C, 1'b0, 32'h4D);
    reset_n = 1'b1;
    tick();
    check("after_busy", {31'd0, busy}, 32'd0);
    look("after_a", 32'h45, 1'b0, 32'h46);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
